// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle control sequencer: FSM states,
// instruction opcodes and ALU function codes.
package ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB
  } state_t;

  // Opcode field, instr[MCODEBITS-1 -: 3]
  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SHL   = 3'b001;
  localparam logic [2:0] OP_SHR   = 3'b010;
  localparam logic [2:0] OP_NAND  = 3'b011;
  localparam logic [2:0] OP_SUB   = 3'b100;
  localparam logic [2:0] OP_LOAD  = 3'b101;
  localparam logic [2:0] OP_STORE = 3'b110;
  localparam logic [2:0] OP_BR    = 3'b111;  // addi when instr[5]=1

  // ALU function codes driven on ALUOp
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SHL  = 3'b001;
  localparam logic [2:0] ALU_SHR  = 3'b010;
  localparam logic [2:0] ALU_NAND = 3'b011;
  localparam logic [2:0] ALU_SUB  = 3'b100;

endpackage

// File: rtl/op_decode.sv
// Combinational instruction decoder: maps the registered IR onto the level
// control fields and the instruction-class flags used by the sequencer.
module op_decode #(
  parameter int OPW       = 3,
  parameter int MCODEBITS = 9
) (
  input  logic [MCODEBITS-1:0] i_ir,
  output logic [OPW-1:0]       o_aluop,
  output logic                 o_alusrc,
  output logic                 o_memtoreg,
  output logic                 o_is_load,
  output logic                 o_is_store,
  output logic                 o_is_branch,
  output logic [1:0]           o_how_high
);
  import ctrl_pkg::*;

  logic [2:0] w_op;
  logic       w_unused;

  assign w_op     = i_ir[MCODEBITS-1 -: 3];
  // Register-select bits are consumed by the datapath, not by control.
  assign w_unused = ^i_ir[2:0];

  // Opcode to control fields; loads, stores and addi compute on the adder.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    o_aluop     = OPW'(ALU_ADD);
    o_alusrc    = 1'b0;
    o_memtoreg  = 1'b0;
    o_is_load   = 1'b0;
    o_is_store  = 1'b0;
    o_is_branch = 1'b0;
    o_how_high  = 2'b00;
    case (w_op)
      OP_ADD:   o_aluop = OPW'(ALU_ADD);
      OP_SHL:   o_aluop = OPW'(ALU_SHL);
      OP_SHR:   o_aluop = OPW'(ALU_SHR);
      OP_NAND:  o_aluop = OPW'(ALU_NAND);
      OP_SUB:   o_aluop = OPW'(ALU_SUB);
      OP_LOAD: begin
        o_memtoreg = 1'b1;
        o_is_load  = 1'b1;
      end
      OP_STORE: o_is_store = 1'b1;
      OP_BR: begin
        if (i_ir[5]) begin
          o_alusrc = 1'b1;
        end else begin
          o_is_branch = 1'b1;
          o_how_high  = i_ir[4:3];
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control sequencer. Walks each instruction through
// FETCH/DECODE/EXEC/MEM/WB, pulses datapath strobes in their owning phase,
// stretches MEM by MEM_WAIT cycles and counts retired instructions.
module multicycle_control #(
  parameter int OPW       = 3,
  parameter int MCODEBITS = 9,
  parameter int MEM_WAIT  = 1,
  parameter int CNTW      = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic                 Halt,
  input  logic [MCODEBITS-1:0] instr,
  input  logic                 zero,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic                 Branch,
  output logic [1:0]           how_high,
  output logic [OPW-1:0]       ALUOp,
  output logic                 ALUSrc,
  output logic                 MemWrite,
  output logic                 MemtoReg,
  output logic                 RegWrite,
  output logic                 Busy,
  output logic                 Done,
  output logic [CNTW-1:0]      retired
);
  import ctrl_pkg::*;

  localparam int             WCW       = (MEM_WAIT < 1) ? 1 : $clog2(MEM_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_WAIT);

  state_t                 r_state;
  state_t                 w_next;
  logic [MCODEBITS-1:0]   r_ir;
  logic [WCW-1:0]         r_wcnt;
  logic [CNTW-1:0]        r_retired;
  logic                   w_is_load;
  logic                   w_is_store;
  logic                   w_is_branch;
  logic                   w_wait_done;

  // Level fields come straight from the IR, which only changes at the end of
  // FETCH, so they are valid from DECODE until the next DECODE.
  op_decode #(
    .OPW       (OPW),
    .MCODEBITS (MCODEBITS)
  ) u_op_decode (
    .i_ir        (r_ir),
    .o_aluop     (ALUOp),
    .o_alusrc    (ALUSrc),
    .o_memtoreg  (MemtoReg),
    .o_is_load   (w_is_load),
    .o_is_store  (w_is_store),
    .o_is_branch (w_is_branch),
    .o_how_high  (how_high)
  );

  assign w_wait_done = (r_wcnt == WAIT_LAST);
  assign Busy        = (r_state != IDLE);
  assign retired     = r_retired;

  // State register; a reset mid-instruction aborts straight to IDLE.
  always_ff @(posedge Clk or posedge Reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (Reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode and single-cycle strobes, all derived from state.
  always_comb begin
    w_next   = r_state;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    Branch   = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    Done     = 1'b0;
    case (r_state)
      IDLE: begin
        if (Start) w_next = FETCH;
      end
      FETCH: begin
        // Halt takes priority over fetching; Start has no meaning here.
        if (Halt) begin
          Done   = 1'b1;
          w_next = IDLE;
        end else begin
          IRWrite = 1'b1;
          w_next  = DECODE;
        end
      end
      DECODE: w_next = EXEC;
      EXEC: begin
        if (w_is_branch) begin
          PCWrite = 1'b1;
          Branch  = zero;
          w_next  = FETCH;
        end else if (w_is_load || w_is_store) begin
          w_next = MEM;
        end else begin
          w_next = WB;
        end
      end
      MEM: begin
        MemWrite = w_is_store && (r_wcnt == '0);
        if (w_wait_done) begin
          if (w_is_store) begin
            PCWrite = 1'b1;
            w_next  = FETCH;
          end else begin
            w_next = WB;
          end
        end
      end
      WB: begin
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
        w_next   = FETCH;
      end
      default: w_next = IDLE;
    endcase
  end

  // Instruction register, loaded once per instruction in FETCH.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)        r_ir <= '0;
    else if (IRWrite) r_ir <= instr;
  end

  // Memory wait counter: cleared on the way into MEM, counts up to MEM_WAIT.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)                                r_wcnt <= '0;
    else if (r_state == EXEC)                 r_wcnt <= '0;
    else if (r_state == MEM && !w_wait_done)  r_wcnt <= r_wcnt + WCW'(1);
  end

  // Retired-instruction counter; an instruction retires on its PCWrite cycle.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)        r_retired <= '0;
    else if (PCWrite) r_retired <= r_retired + CNTW'(1);
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control (MEM_WAIT=2, CNTW=4).
// Each cycle's expected output vector is pushed to a scoreboard queue as the
// stimulus is driven and popped for comparison at the following falling edge.
module tb_multicycle_control;
  import ctrl_pkg::*;

  localparam int MW = 2;

  logic       Clk = 1'b0;
  logic       Reset, Start, Halt, zero;
  logic [8:0] instr;
  logic       IRWrite, PCWrite, Branch, ALUSrc, MemWrite, MemtoReg, RegWrite, Busy, Done;
  logic [1:0] how_high;
  logic [2:0] ALUOp;
  logic [3:0] retired;

  typedef struct packed {
    logic       irw;
    logic       pcw;
    logic       br;
    logic [1:0] hh;
    logic [2:0] aluop;
    logic       alusrc;
    logic       memw;
    logic       m2r;
    logic       regw;
    logic       busy;
    logic       done;
    logic [3:0] ret;
  } obs_t;

  obs_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: level fields and retired count as the spec defines them.
  logic [2:0] m_aluop;
  logic       m_alusrc, m_m2r;
  logic [1:0] m_hh;
  logic [3:0] m_ret;

  multicycle_control #(
    .OPW(3), .MCODEBITS(9), .MEM_WAIT(MW), .CNTW(4)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt), .instr(instr), .zero(zero),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .Branch(Branch), .how_high(how_high),
    .ALUOp(ALUOp), .ALUSrc(ALUSrc), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .Busy(Busy), .Done(Done), .retired(retired)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
    $fatal(1, "watchdog");
  end

  function automatic obs_t observe();
    obs_t o;
    o.irw = IRWrite;  o.pcw = PCWrite;   o.br = Branch;     o.hh = how_high;
    o.aluop = ALUOp;  o.alusrc = ALUSrc; o.memw = MemWrite; o.m2r = MemtoReg;
    o.regw = RegWrite; o.busy = Busy;    o.done = Done;     o.ret = retired;
    return o;
  endfunction

  function automatic obs_t base(input logic busy);
    obs_t e = '0;
    e.aluop = m_aluop; e.alusrc = m_alusrc; e.m2r = m_m2r; e.hh = m_hh;
    e.ret = m_ret;     e.busy = busy;
    return e;
  endfunction

  task automatic model_reset();
    m_aluop = 3'b000; m_alusrc = 1'b0; m_m2r = 1'b0; m_hh = 2'b00; m_ret = 4'd0;
    sb.delete();
  endtask

  task automatic chk(input obs_t o, input obs_t e, input string tag);
    n_checks++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, o, e);
    end
  endtask

  // One clock cycle: push expectation, drive inputs, compare at falling edge.
  task automatic cyc(input logic st, input logic hl, input logic [8:0] ins,
                     input logic z, input obs_t exp, input string tag);
    obs_t e;
    sb.push_back(exp);
    Start = st; Halt = hl; instr = ins; zero = z;
    @(negedge Clk);
    e = sb.pop_front();
    chk(observe(), e, tag);
    @(posedge Clk);
    #1;
  endtask

  // Runs one instruction starting in FETCH. abort_mem >= 0 stops after that
  // MEM cycle without retiring (used for the mid-MEM reset).
  task automatic run_instr(input string name, input logic [8:0] ins, input logic z,
                           input logic st_noise, input logic hl_noise, input int abort_mem);
    obs_t       e;
    logic [2:0] op;
    logic       is_alu, is_ld, is_st, is_addi, is_br;
    op      = ins[8:6];
    is_alu  = (op <= 3'd4);
    is_ld   = (op == 3'd5);
    is_st   = (op == 3'd6);
    is_addi = (op == 3'd7) &&  ins[5];
    is_br   = (op == 3'd7) && !ins[5];

    e = base(1'b1); e.irw = 1'b1;
    cyc(1'b0, 1'b0, ins, z, e, {name, ":fetch"});

    m_aluop  = is_alu ? op : 3'b000;
    m_alusrc = is_addi;
    m_m2r    = is_ld;
    m_hh     = is_br ? ins[4:3] : 2'b00;

    e = base(1'b1);
    cyc(st_noise, 1'b0, ~ins, z, e, {name, ":decode"});

    e = base(1'b1);
    if (is_br) begin e.pcw = 1'b1; e.br = z; end
    cyc(1'b0, hl_noise, ~ins, z, e, {name, ":exec"});
    if (is_br) begin m_ret = m_ret + 4'd1; return; end

    if (is_ld || is_st) begin
      for (int k = 0; k <= MW; k++) begin
        e = base(1'b1);
        if (is_st && k == 0)  e.memw = 1'b1;
        if (is_st && k == MW) e.pcw  = 1'b1;
        cyc(1'b0, 1'b0, ~ins, ~z, e, $sformatf("%s:mem%0d", name, k));
        if (k == abort_mem) return;
      end
      if (is_st) begin m_ret = m_ret + 4'd1; return; end
    end

    e = base(1'b1); e.regw = 1'b1; e.pcw = 1'b1;
    cyc(1'b0, 1'b0, ~ins, z, e, {name, ":wb"});
    m_ret = m_ret + 4'd1;
  endtask

  task automatic start_cycle(input logic st, input string tag);
    cyc(st, 1'b0, 9'h000, 1'b0, base(1'b0), tag);
  endtask

  task automatic halt_seq(input logic st, input string tag);
    obs_t e;
    e = base(1'b1); e.done = 1'b1;
    cyc(st, 1'b1, 9'h1ff, 1'b0, e, {tag, ":done"});
    cyc(1'b0, 1'b0, 9'h000, 1'b0, base(1'b0), {tag, ":idle"});
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; Halt = 1'b0; instr = '0; zero = 1'b0;
    model_reset();
    #2;
    chk(observe(), obs_t'(0), "reset_outputs");

    // Start held during the last reset edge must not leave IDLE.
    Start = 1'b1;
    @(posedge Clk);
    #1;
    Reset = 1'b0; Start = 1'b0;
    start_cycle(1'b0, "start_with_reset_ignored");
    start_cycle(1'b0, "idle_hold");
    start_cycle(1'b1, "start");

    // ALU ops; Start in DECODE and Halt in EXEC are ignored; zero=1 never
    // produces Branch outside a branch.
    run_instr("add",  9'b000_101101, 1'b1, 1'b1, 1'b1, -1);
    run_instr("shl",  9'b001_010011, 1'b0, 1'b0, 1'b0, -1);
    run_instr("shr",  9'b010_111000, 1'b1, 1'b0, 1'b0, -1);
    run_instr("nand", 9'b011_000111, 1'b0, 1'b0, 1'b0, -1);
    run_instr("sub",  9'b100_110110, 1'b1, 1'b0, 1'b0, -1);
    run_instr("addi", 9'b111_1_01010, 1'b1, 1'b0, 1'b0, -1);
    run_instr("br_t", 9'b111_0_10_101, 1'b1, 1'b0, 1'b0, -1);
    run_instr("br_n", 9'b111_0_10_101, 1'b0, 1'b0, 1'b0, -1);
    run_instr("br_11", 9'b111_0_11_000, 1'b1, 1'b0, 1'b0, -1);
    run_instr("store", 9'b110_011001, 1'b0, 1'b0, 1'b0, -1);
    run_instr("load",  9'b101_100100, 1'b1, 1'b0, 1'b0, -1);

    halt_seq(1'b0, "halt");
    start_cycle(1'b1, "restart");
    for (int i = 0; i < 8; i++) begin
      run_instr($sformatf("rnd%0d", i), 9'($urandom), 1'($urandom), 1'b0, 1'b0, -1);
    end
    // Start and Halt together in FETCH: Halt wins.
    halt_seq(1'b1, "start_and_halt");

    // Abort a load in the middle of MEM with an asynchronous reset.
    start_cycle(1'b1, "start_for_abort");
    run_instr("load_abort", 9'b101_001010, 1'b0, 1'b0, 1'b0, 1);
    Reset = 1'b1;
    #1;
    model_reset();
    chk(observe(), obs_t'(0), "reset_mid_mem_outputs");
    n_checks++;
    assert (dut.r_state === IDLE) else begin
      n_fail++;
      $error("FAIL reset_mid_mem_state: observed %0d expected %0d", dut.r_state, IDLE);
    end
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    start_cycle(1'b0, "after_reset_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
